regfile_dumper: RTL and testbench



---
 rtl/regfile_dumper_pkg.sv | 22 ++
 rtl/regfile_dumper_if.sv | 31 +++
 rtl/regfile_dumper_out_stage.sv | 56 +++++
 rtl/regfile_dumper.sv | 135 +++++++++++++
 tb/tb_regfile_dumper.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dumper_pkg.sv
// Shared types and sizing for the register-file dump path.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND0,
    SEND1,
    DONE
  } dump_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Valid/ready beat stream carrying (address, value) pairs out of the dumper.
interface regfile_dumper_if
  import regfile_pkg::*;
#(
  parameter int AW = regfile_pkg::ADDR_W,
  parameter int DW = regfile_pkg::DATA_W
);

  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dumper_out_stage.sv
// Pair capture buffer and registered valid/ready output; the beat holds until accepted.
module dump_out_stage
  import regfile_pkg::*;
#(
  parameter int AW = regfile_pkg::ADDR_W,
  parameter int DW = regfile_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap,
  input  logic          adv,
  input  logic          fin,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          last_pair,
  regfile_dumper_if.master dout
);

  logic [DW-1:0] buf0;
  logic [DW-1:0] buf1;
  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic          last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf0    <= '0;
      buf1    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else if (cap) begin
      buf0    <= rdata1;
      buf1    <= rdata2;
      valid_q <= 1'b1;
      addr_q  <= addr0;
      last_q  <= 1'b0;
    end else if (adv) begin
      addr_q  <= addr1;
      last_q  <= last_pair;
    end else if (fin) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  // Even beat shows buf0, odd beat shows buf1; both are registers so the
  // presented word cannot move while backpressured.
  assign dout.out_valid = valid_q;
  assign dout.out_addr  = addr_q;
  assign dout.out_data  = addr_q[0] ? buf1 : buf0;
  assign dout.out_last  = last_q;

endmodule

// File: rtl/regfile_dumper.sv
// Walks both register-file read ports over all registers and streams each
// (address, value) beat. Checksum accumulator built only with REGFILE_DUMPER_CHECKSUM_EN.
module regfile_dumper
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] checksum,
  regfile_dumper_if.master  dout
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | read addresses settle, both words captured at closing edge
  // SEND0 | even register beat presented
  // SEND1 | odd register beat presented, then next pair or finish
  // DONE  | one-cycle done pulse

  localparam int KW = ADDR_W - 1;
  localparam logic [KW-1:0] KLAST = KW'(NREGS / 2 - 1);

  dump_state_t   state;
  logic [KW-1:0] k;
  logic          hs;
  logic          last_pair;
  logic          cap;
  logic          adv;
  logic          fin;

  assign hs        = dout.out_valid & dout.out_ready;
  assign last_pair = (k == KLAST);
  assign cap       = (state == READ);
  assign adv       = (state == SEND0) && hs;
  assign fin       = (state == SEND1) && hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      raddr1 <= '0;
      raddr2 <= ADDR_W'(1);
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= READ;
            k      <= '0;
            raddr1 <= '0;
            raddr2 <= ADDR_W'(1);
            busy   <= 1'b1;
          end
        end
        READ: begin
          state <= SEND0;
        end
        SEND0: begin
          if (hs) state <= SEND1;
        end
        SEND1: begin
          if (hs) begin
            if (last_pair) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              k      <= k + 1'b1;
              raddr1 <= {k + 1'b1, 1'b0};
              raddr2 <= {k + 1'b1, 1'b1};
              state  <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  dump_out_stage #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap),
    .adv       (adv),
    .fin       (fin),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .addr0     (raddr1),
    .addr1     (raddr2),
    .last_pair (last_pair),
    .dout      (dout)
  );

`ifdef REGFILE_DUMPER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Carry out of the top bit is dropped so the sum wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state == IDLE && start) begin
      sum_q <= '0;
    end else if (adv || fin) begin
      sum_q <= sum_q + dout.out_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: stimulus pushes expected beats, a monitor pops and compares.
module tb_regfile_dumper;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] checksum;
  logic              ready = 1'b1;

  logic [DATA_W-1:0] rf [NREGS];

  regfile_dumper_if #(.AW(ADDR_W), .DW(DATA_W)) dif ();

  assign rdata1        = rf[raddr1];
  assign rdata2        = rf[raddr2];
  assign dif.out_ready = ready;

  regfile_dumper dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .checksum (checksum),
    .dout     (dif.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;
  int rdy_mode = 0;
  bit timed    = 0;
  int beats_seen = 0;
  int done_cnt   = 0;
  beat_t exp_q[$];
  logic [DATA_W-1:0] exp_sum;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops expected beats on each handshake and checks hold/done behaviour.
  initial begin
    bit    held_prev = 0;
    bit    done_prev = 0;
    beat_t held_beat;
    beat_t cur;
    beat_t e;
    forever begin
      @(negedge clk);
      cur = '{addr: dif.out_addr, data: dif.out_data, last: dif.out_last};
      if (rst) begin
        held_prev = 0;
        done_prev = 0;
      end else begin
        if (held_prev) begin
          chk("hold_valid", 64'(dif.out_valid), 64'd1);
          chk("hold_beat", 64'(cur), 64'(held_beat));
        end
        if (done_prev) chk("done_width", 64'(done), 64'd0);
`ifndef REGFILE_DUMPER_CHECKSUM_EN
        if (dif.out_valid) chk("checksum_tied_zero", 64'(checksum), 64'd0);
`endif
        if (dif.out_valid && dif.out_ready) begin
          beats_seen++;
          chk("busy_on_beat", 64'(busy), 64'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_beat: got addr %0d, no beat expected", cur.addr);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", 64'(cur.addr), 64'(e.addr));
            chk("beat_data", 64'(cur.data), 64'(e.data));
            chk("beat_last", 64'(cur.last), 64'(e.last));
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_beats_left", 64'(exp_q.size()), 64'd0);
          chk("done_checksum", 64'(checksum), 64'(exp_sum));
          chk("done_busy", 64'(busy), 64'd1);
          if (timed) chk("done_latency", 64'(cyc - t_start), 64'd48);
        end
        held_prev = dif.out_valid && !dif.out_ready;
        held_beat = cur;
        done_prev = done;
      end
    end
  end

  // Reference model: expected stream is simply every register in index order.
  task automatic load_expect();
    logic [DATA_W-1:0] s;
    exp_q.delete();
    s = '0;
    for (int i = 0; i < NREGS; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: rf[i], last: (i == NREGS - 1)});
      s = s + rf[i];
    end
`ifdef REGFILE_DUMPER_CHECKSUM_EN
    exp_sum = s;
`else
    exp_sum = '0;
`endif
  endtask

  task automatic run_dump(input bit is_timed, input int mode, input bit poke);
    int  n;
    bit  got;
    int  beats0;
    load_expect();
    rdy_mode = mode;
    timed    = is_timed;
    beats0   = beats_seen;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 t_start = cyc;
    start = 1'b0;
    got = 0;
    for (n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (poke)
        start = (dif.out_valid && (dif.out_addr == ADDR_W'(5) || dif.out_addr == ADDR_W'(31))) || done;
      if (done) got = 1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done, required done within 3000 cycles");
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("after_busy", 64'(busy), 64'd0);
    chk("after_valid", 64'(dif.out_valid), 64'd0);
    chk("beat_count", 64'(beats_seen - beats0), 64'(NREGS));
    timed = 0;
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NREGS; i++) rf[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(dif.out_valid), 64'd0);
    chk("rst_last", 64'(dif.out_last), 64'd0);
    chk("rst_addr", 64'(dif.out_addr), 64'd0);
    chk("rst_data", 64'(dif.out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    chk("rst_raddr1", 64'(raddr1), 64'd0);
    chk("rst_raddr2", 64'(raddr2), 64'd1);
    rst = 1'b0;

    rf[1]  = 32'hFFFF_FFFF;
    rf[7]  = 32'h0000_0101;
    rf[10] = 32'h0000_0001;
    run_dump(1, 0, 0);
    chk("preload_sum_model", 64'(exp_sum),
`ifdef REGFILE_DUMPER_CHECKSUM_EN
        64'h101
`else
        64'h0
`endif
    );
    run_dump(0, 1, 0);
    run_dump(1, 0, 1);

    // Reset while register 10 is on the bus.
    load_expect();
    rdy_mode = 2;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (dif.out_valid && dif.out_addr == ADDR_W'(10)) break;
    end
    chk("midrst_reached_addr10", 64'(dif.out_addr), 64'd10);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(dif.out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_checksum", 64'(checksum), 64'd0);
    chk("midrst_raddr1", 64'(raddr1), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    run_dump(0, 2, 0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
      run_dump(0, 2, 0);
    end
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
    run_dump(1, 0, 0);

    chk("done_pulses", 64'(done_cnt), 64'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
